// File: rtl/el2_trace_encoder_pkg.sv
// Shared types for the trace encoder: core trace packet, capture-FIFO entry, serialiser states.
// Optional `RV_TRACE_TIMESTAMP_EN adds a 16-bit timestamp per entry and two trailing TS states.
package el2_trace_encoder_pkg;

    typedef struct packed {
        logic [31:0] trace_rv_i_insn_ip;
        logic [31:0] trace_rv_i_address_ip;
        logic        trace_rv_i_valid_ip;
        logic        trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic        trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } el2_trace_pkt_t;

    typedef enum logic [1:0] {
        TR_SEQ  = 2'b00,
        TR_FULL = 2'b01,
        TR_EXC  = 2'b10,
        TR_OVF  = 2'b11
    } el2_trace_rec_t;

    typedef struct packed {
        el2_trace_rec_t rec;
        logic           is16;
        logic           ovf;
        logic [5:0]     drop_cnt;
        logic [31:0]    addr;
        logic [31:0]    data;
        logic [4:0]     ecause;
        logic           intr;
`ifdef RV_TRACE_TIMESTAMP_EN
        logic [15:0]    ts;
`endif
    } el2_trace_ent_t;

    typedef enum logic [2:0] {
        SER_IDLE,
        SER_OVF,
        SER_HDR,
        SER_PAY
`ifdef RV_TRACE_TIMESTAMP_EN
        , SER_TS0
        , SER_TS1
`endif
    } el2_trace_ser_state_t;

    localparam logic [2:0] TR_LAST_PAY = 3'd7;

    function automatic logic [7:0] tr_header(input el2_trace_ent_t ent);
        logic [7:0] hdr;
        case (ent.rec)
            TR_EXC:  hdr = {2'b10, ent.ecause, ent.intr};
            TR_SEQ:  hdr = {2'b00, 5'b0, ent.is16};
            default: hdr = {2'b01, 5'b0, ent.is16};
        endcase
        return hdr;
    endfunction

endpackage

// File: rtl/el2_trace_ser.sv
// Byte serialiser: pops capture-FIFO entries and streams OVF/HDR/payload(/TS) bytes on valid/ready.
// Timestamp bytes are present only with `RV_TRACE_TIMESTAMP_EN.
module el2_trace_ser
    import el2_trace_encoder_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  el2_trace_ent_t head,
    input  logic           fifo_empty,
    output logic           pop,
    output logic [7:0]     tr_byte,
    output logic           tr_byte_valid,
    input  logic           tr_byte_ready,
    output logic           ser_busy
);

    el2_trace_ser_state_t state, state_nxt;
    logic [2:0]           idx, idx_nxt;
    el2_trace_ent_t       cur;
    logic [7:0]           byte_sel;
    logic                 last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SER_IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) cur <= head;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pop       = 1'b0;
        byte_sel  = 8'h00;
        last      = 1'b0;
        case (state)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = head.ovf ? SER_OVF : SER_HDR;
                end
            end
            SER_OVF: begin
                byte_sel = {2'b11, cur.drop_cnt};
                if (tr_byte_ready) state_nxt = SER_HDR;
            end
            SER_HDR: begin
                byte_sel = tr_header(cur);
                if (cur.rec == TR_SEQ) begin
                    last = 1'b1;
                end else if (tr_byte_ready) begin
                    state_nxt = SER_PAY;
                    idx_nxt   = 3'd0;
                end
            end
            SER_PAY: begin
                // idx 0..3 walk the address, 4..7 the insn/tval word, LSB first
                byte_sel = idx[2] ? cur.data[{idx[1:0], 3'b000} +: 8]
                                  : cur.addr[{idx[1:0], 3'b000} +: 8];
`ifdef RV_TRACE_TIMESTAMP_EN
                if (tr_byte_ready && idx == TR_LAST_PAY) state_nxt = SER_TS0;
`else
                if (idx == TR_LAST_PAY) last = 1'b1;
`endif
                if (tr_byte_ready) idx_nxt = idx + 3'd1;
            end
`ifdef RV_TRACE_TIMESTAMP_EN
            SER_TS0: begin
                byte_sel = cur.ts[7:0];
                if (tr_byte_ready) state_nxt = SER_TS1;
            end
            SER_TS1: begin
                byte_sel = cur.ts[15:8];
                last     = 1'b1;
            end
`endif
            default: state_nxt = SER_IDLE;
        endcase

        // Chain straight into the next record so back-to-back records have no bubble
        if (last && tr_byte_ready) begin
            if (!fifo_empty) begin
                pop       = 1'b1;
                state_nxt = head.ovf ? SER_OVF : SER_HDR;
            end else begin
                state_nxt = SER_IDLE;
            end
        end
    end

    assign tr_byte_valid = (state != SER_IDLE);
    assign tr_byte       = byte_sel;
    assign ser_busy      = tr_byte_valid;

endmodule

// File: rtl/el2_trace_encoder.sv
// Trace encoder top: classifies retire packets (SEQ/FULL/EXC), tracks drops, buffers in a capture FIFO.
// `RV_TRACE_TIMESTAMP_EN enables a free-running 16-bit timestamp captured per entry.
module el2_trace_encoder
    import el2_trace_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  el2_trace_pkt_t trace_pkt,
    input  logic           trace_enable,
    output logic [7:0]     tr_byte,
    output logic           tr_byte_valid,
    input  logic           tr_byte_ready,
    output logic           tr_drop,
    output logic           tr_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    el2_trace_ent_t   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty, fifo_full;
    logic             cap, enq, drop, pop, exc, seq, is16;
    logic [31:0]      exp_pc;
    logic             exp_vld;
    logic [5:0]       drop_cnt;
    logic             pending_ovf;
    logic             ser_busy;
    el2_trace_ent_t   ent_in;
`ifdef RV_TRACE_TIMESTAMP_EN
    logic [15:0]      ts;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign cap        = trace_pkt.trace_rv_i_valid_ip & trace_enable;
    assign enq        = cap & !fifo_full;
    assign drop       = cap & fifo_full;
    assign exc        = trace_pkt.trace_rv_i_exception_ip | trace_pkt.trace_rv_i_interrupt_ip;
    assign is16       = (trace_pkt.trace_rv_i_insn_ip[1:0] != 2'b11);
    // A record following drops must resync the sink, so it is never compressed
    assign seq        = exp_vld & (trace_pkt.trace_rv_i_address_ip == exp_pc) & !pending_ovf & !exc;

    always_comb begin
        ent_in          = '0;
        ent_in.rec      = exc ? TR_EXC : (seq ? TR_SEQ : TR_FULL);
        ent_in.is16     = is16;
        ent_in.ovf      = pending_ovf;
        ent_in.drop_cnt = drop_cnt;
        ent_in.addr     = trace_pkt.trace_rv_i_address_ip;
        ent_in.data     = exc ? trace_pkt.trace_rv_i_tval_ip : trace_pkt.trace_rv_i_insn_ip;
        ent_in.ecause   = trace_pkt.trace_rv_i_ecause_ip;
        ent_in.intr     = trace_pkt.trace_rv_i_interrupt_ip;
`ifdef RV_TRACE_TIMESTAMP_EN
        ent_in.ts       = ts;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            exp_vld     <= 1'b0;
            drop_cnt    <= 6'd0;
            pending_ovf <= 1'b0;
            tr_drop     <= 1'b0;
        end else begin
            tr_drop <= drop;
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!trace_enable || drop || (cap && exc)) exp_vld <= 1'b0;
            else if (enq)                              exp_vld <= 1'b1;
            if (drop) begin
                drop_cnt    <= (drop_cnt == 6'd63) ? drop_cnt : drop_cnt + 6'd1;
                pending_ovf <= 1'b1;
            end else if (enq && pending_ovf) begin
                drop_cnt    <= 6'd0;
                pending_ovf <= 1'b0;
            end
        end
    end

`ifdef RV_TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= 16'd0;
        else     ts <= ts + 16'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= ent_in;
            exp_pc      <= trace_pkt.trace_rv_i_address_ip + (is16 ? 32'd2 : 32'd4);
        end
    end

    el2_trace_ser u_ser (
        .clk           (clk),
        .rst           (rst),
        .head          (mem[rd_ptr]),
        .fifo_empty    (fifo_empty),
        .pop           (pop),
        .tr_byte       (tr_byte),
        .tr_byte_valid (tr_byte_valid),
        .tr_byte_ready (tr_byte_ready),
        .ser_busy      (ser_busy)
    );

    assign tr_busy = !fifo_empty | ser_busy;

endmodule

// File: tb/tb_el2_trace_encoder.sv
// Self-checking bench for el2_trace_encoder: vector table plus stall/drop/overflow and mid-record reset.
// Timestamp bytes are expected only when built with `RV_TRACE_TIMESTAMP_EN.
module tb_el2_trace_encoder;
    import el2_trace_encoder_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    el2_trace_pkt_t trace_pkt;
    logic           trace_enable;
    logic [7:0]     tr_byte;
    logic           tr_byte_valid;
    logic           tr_byte_ready;
    logic           tr_drop;
    logic           tr_busy;

    el2_trace_encoder #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .trace_pkt     (trace_pkt),
        .trace_enable  (trace_enable),
        .tr_byte       (tr_byte),
        .tr_byte_valid (tr_byte_valid),
        .tr_byte_ready (tr_byte_ready),
        .tr_drop       (tr_drop),
        .tr_busy       (tr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] insn;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic [7:0]  hdr;
        logic        pay;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         failures = 0;
    int         hs_cnt = 0;
    int         drop_seen = 0;
    int         ready_mode = 0;
`ifdef RV_TRACE_TIMESTAMP_EN
    logic [15:0] tb_ts = 16'd0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) tb_ts = 16'd0;
            else     tb_ts = tb_ts + 16'd1;
        end
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        tr_byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tr_byte_ready = 1'b1;
                1:       tr_byte_ready = 1'b0;
                default: tr_byte_ready = ~tr_byte_ready;
            endcase
        end
    end

    // Byte monitor: scoreboard pop on handshake, hold-stability while stalled, drop pulse count
    initial begin
        logic       prev_stall;
        logic [7:0] prev_byte;
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(tr_byte_valid), 32'h1);
                    check("hold_byte", 32'(tr_byte), 32'(prev_byte));
                end
                if (tr_byte_valid && tr_byte_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_byte actual=%h required=none", tr_byte);
                    end else begin
                        check("byte", 32'(tr_byte), 32'(exp_q.pop_front()));
                    end
                end
                if (tr_drop) drop_seen++;
                prev_stall = tr_byte_valid && !tr_byte_ready;
                prev_byte  = tr_byte;
            end
        end
    end

    task automatic send(input logic en, input logic [31:0] addr, input logic [31:0] insn,
                        input logic exc, input logic intr, input logic [4:0] ecause,
                        input logic [31:0] tval);
        @(posedge clk);
        #1;
        trace_enable                      = en;
        trace_pkt.trace_rv_i_valid_ip     = 1'b1;
        trace_pkt.trace_rv_i_address_ip   = addr;
        trace_pkt.trace_rv_i_insn_ip      = insn;
        trace_pkt.trace_rv_i_exception_ip = exc;
        trace_pkt.trace_rv_i_interrupt_ip = intr;
        trace_pkt.trace_rv_i_ecause_ip    = ecause;
        trace_pkt.trace_rv_i_tval_ip      = tval;
    endtask

    task automatic idle_pkt();
        @(posedge clk);
        #1;
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
        trace_enable                  = 1'b1;
    endtask

    task automatic push_rec(input logic [7:0] hdr, input logic pay, input logic [31:0] addr,
                            input logic [31:0] data);
        exp_q.push_back(hdr);
        if (pay) begin
            for (int b = 0; b < 4; b++) exp_q.push_back(addr[8*b +: 8]);
            for (int b = 0; b < 4; b++) exp_q.push_back(data[8*b +: 8]);
`ifdef RV_TRACE_TIMESTAMP_EN
            exp_q.push_back(tb_ts[7:0]);
            exp_q.push_back(tb_ts[15:8]);
`endif
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tr_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_bytes_pending required=0", name, exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drop_base;
        int hs_base;
        int n;

        vecs[0]  = '{1'b1, 32'h100, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h40, 1'b1};
        vecs[1]  = '{1'b1, 32'h104, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h00, 1'b0};
        vecs[2]  = '{1'b1, 32'h200, 32'h4501, 1'b0, 1'b0, 5'd0, 32'h0,        8'h41, 1'b1};
        vecs[3]  = '{1'b1, 32'h202, 32'h4501, 1'b0, 1'b0, 5'd0, 32'h0,        8'h01, 1'b0};
        vecs[4]  = '{1'b1, 32'h208, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h40, 1'b1};
        vecs[5]  = '{1'b1, 32'h300, 32'h13,   1'b1, 1'b0, 5'd2, 32'hDEADBEEF, 8'h84, 1'b1};
        vecs[6]  = '{1'b1, 32'h304, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h40, 1'b1};
        vecs[7]  = '{1'b1, 32'h308, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h00, 1'b0};
        vecs[8]  = '{1'b1, 32'h30C, 32'h13,   1'b0, 1'b1, 5'd7, 32'h0,        8'h8F, 1'b1};
        vecs[9]  = '{1'b1, 32'h400, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h40, 1'b1};
        vecs[10] = '{1'b0, 32'h404, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h00, 1'b0};
        vecs[11] = '{1'b1, 32'h404, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h40, 1'b1};
        vecs[12] = '{1'b1, 32'h408, 32'h13,   1'b0, 1'b0, 5'd0, 32'h0,        8'h00, 1'b0};

        rst          = 1'b1;
        trace_pkt    = '0;
        trace_enable = 1'b1;
        ready_mode   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte", 32'(tr_byte), 32'h0);
        check("rst_valid", 32'(tr_byte_valid), 32'h0);
        check("rst_drop", 32'(tr_drop), 32'h0);
        check("rst_busy", 32'(tr_busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            send(vecs[i].en, vecs[i].addr, vecs[i].insn, vecs[i].exc, vecs[i].intr,
                 vecs[i].ecause, vecs[i].tval);
            if (vecs[i].en)
                push_rec(vecs[i].hdr, vecs[i].pay, vecs[i].addr,
                         (vecs[i].exc | vecs[i].intr) ? vecs[i].tval : vecs[i].insn);
            idle_pkt();
            drain($sformatf("vec%0d", i));
        end
        check("no_drops_in_table", 32'(drop_seen), 32'h0);

        // Stalled sink: one record in flight, FIFO fills with four SEQ, three packets dropped
        ready_mode = 1;
        drop_base  = drop_seen;
        send(1'b1, 32'h500, 32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
        push_rec(8'h40, 1'b1, 32'h500, 32'h13);
        idle_pkt();
        repeat (2) @(negedge clk);
        check("stall_valid", 32'(tr_byte_valid), 32'h1);
        check("stall_byte", 32'(tr_byte), 32'h40);
        check("stall_busy", 32'(tr_busy), 32'h1);
        for (int i = 0; i < 7; i++) begin
            send(1'b1, 32'h504 + 32'(4 * i), 32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
            if (i < 4) push_rec(8'h00, 1'b0, 32'h0, 32'h0);
        end
        idle_pkt();
        repeat (3) @(negedge clk);
        check("drop_pulses", 32'(drop_seen - drop_base), 32'd3);
        ready_mode = 0;
        drain("stall");

        // Next capture after the drops is announced by OVF and never compressed
        send(1'b1, 32'h520, 32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_q.push_back(8'hC3);
        push_rec(8'h40, 1'b1, 32'h520, 32'h13);
        idle_pkt();
        drain("ovf");
        check("drop_total", 32'(drop_seen - drop_base), 32'd3);

        // Reset in the middle of a payload with a toggling sink
        ready_mode = 2;
        hs_base    = hs_cnt;
        send(1'b1, 32'h700, 32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
        push_rec(8'h40, 1'b1, 32'h700, 32'h13);
        idle_pkt();
        n = 0;
        while (hs_cnt < hs_base + 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrec_reach", 32'(n < 100), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrec_valid", 32'(tr_byte_valid), 32'h0);
        check("midrec_busy", 32'(tr_busy), 32'h0);
        check("midrec_byte", 32'(tr_byte), 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        ready_mode = 0;
        send(1'b1, 32'h704, 32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
        push_rec(8'h40, 1'b1, 32'h704, 32'h13);
        idle_pkt();
        drain("post_reset");

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("idle_busy", 32'(tr_busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
